// File: rtl/shift_add_datapath.sv
// Datapath of the sequential shift-add unsigned multiplier: executes the
// control unit's per-cycle codes and captures the product on the rise of ready.
module shift_add_datapath #(
  parameter int n = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic [1:0]     c_sh_rg,
  input  logic [1:0]     c_cnt,
  input  logic           ready,
  output logic           y,
  output logic [2*n-1:0] product,
  output logic           product_valid
);

  localparam logic [1:0] CODE_LOAD  = 2'd3;
  localparam logic [1:0] CODE_SHIFT = 2'd2;
  localparam logic [1:0] CODE_ADD   = 2'd2;

  logic [n-1:0]   sh_rg;
  logic [2*n-1:0] mcand;
  logic [2*n-1:0] acc;
  logic           ready_d;

  assign y = sh_rg[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_rg <= '0;
    end else if (c_sh_rg == CODE_LOAD) begin
      sh_rg <= b;
    end else if (c_sh_rg == CODE_SHIFT) begin
      sh_rg <= {1'b0, sh_rg[n-1:1]};
    end
  end

  // The add uses the pre-shift multiplicand, so bit i of b is weighted by a<<i.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (c_cnt == CODE_LOAD) begin
      acc <= '0;
    end else if (c_cnt == CODE_ADD) begin
      acc <= acc + mcand;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand <= '0;
    end else if (c_cnt == CODE_LOAD) begin
      mcand <= {{n{1'b0}}, a};
    end else if (c_sh_rg == CODE_SHIFT) begin
      mcand <= mcand << 1;
    end
  end

  // Capture on the rising edge of ready only; a long ready gives one strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_d       <= 1'b0;
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      ready_d <= ready;
      if (ready && !ready_d) begin
        product       <= acc;
        product_valid <= 1'b1;
      end else begin
        product_valid <= 1'b0;
      end
    end
  end

endmodule
